// File: rtl/frequency_modulator.sv
// NCO-based FM modulator: integrates signed frequency words into a phase
// and maps it through a quarter-wave sine ROM to a constant-envelope I/Q pair.
module frequency_modulator #(
    parameter int IN_W     = 12,
    parameter int OUT_W    = 12,
    parameter int PHASE_W  = 16,
    parameter int SHIFT    = 4,
    parameter int LUT_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int  N   = 2 ** LUT_BITS;
    localparam int  AMP = 2 ** (OUT_W - 1) - 1;
    localparam real PI  = 3.14159265358979323846;

    if (IN_W + SHIFT > PHASE_W) begin : g_bad_width
        $error("frequency_modulator: IN_W+SHIFT must not exceed PHASE_W");
    end

    // Quarter-wave table, entries 0..N inclusive so the cosine lookup
    // R[N-idx] never needs a special case at idx=0.
    logic [OUT_W-1:0] rom [0:N];

    for (genvar j = 0; j <= N; j++) begin : g_rom
        localparam real ANG = j * PI / (2.0 ** (LUT_BITS + 1));
        localparam int  VAL = $rtoi(real'(AMP) * $sin(ANG) + 0.5);
        assign rom[j] = OUT_W'(VAL);
    end

    logic               en;
    logic               take;
    logic [PHASE_W-1:0] inc;

    assign en       = out_ready | ~out_valid;
    assign in_ready = rst_n & en;
    assign take     = in_valid & in_ready;
    assign inc      = PHASE_W'(in) << SHIFT;

    logic               v0;
    logic [PHASE_W-1:0] inc0;
    logic [PHASE_W-1:0] acc;
    logic               v1;
    logic [1:0]         quad1;
    logic [LUT_BITS-1:0] idx1;
    logic               v2;
    logic [1:0]         quad2;
    logic signed [OUT_W-1:0] s2;
    logic signed [OUT_W-1:0] c2;

    logic [LUT_BITS:0]  sidx;
    logic [LUT_BITS:0]  cidx;
    logic signed [OUT_W-1:0] map_i;
    logic signed [OUT_W-1:0] map_q;

    assign sidx = {1'b0, idx1};
    assign cidx = (LUT_BITS + 1)'(N) - sidx;

    always_comb begin
        map_i = c2;
        map_q = s2;
        unique case (quad2)
            2'd0: begin map_i = c2;  map_q = s2;  end
            2'd1: begin map_i = -s2; map_q = c2;  end
            2'd2: begin map_i = -c2; map_q = -s2; end
            2'd3: begin map_i = s2;  map_q = -c2; end
        endcase
    end

    // Phase for a sample is the accumulator value before its own increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            inc0      <= '0;
            acc       <= '0;
            v1        <= 1'b0;
            quad1     <= '0;
            idx1      <= '0;
            v2        <= 1'b0;
            quad2     <= '0;
            s2        <= '0;
            c2        <= '0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else if (en) begin
            v0 <= take;
            if (take) begin
                inc0 <= inc;
            end
            v1 <= v0;
            if (v0) begin
                acc   <= acc + inc0;
                quad1 <= acc[PHASE_W-1 -: 2];
                idx1  <= acc[PHASE_W-3 -: LUT_BITS];
            end
            v2 <= v1;
            if (v1) begin
                quad2 <= quad1;
                s2    <= rom[sidx];
                c2    <= rom[cidx];
            end
            out_valid <= v2;
            if (v2) begin
                out_i <= map_i;
                out_q <= map_q;
            end
        end
    end

endmodule

// File: tb/tb_frequency_modulator.sv
// Scoreboard bench for frequency_modulator: a trig-based phase model predicts
// each I/Q sample at input transfer and the monitor checks it at output transfer.
module tb_frequency_modulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [11:0] in;
    logic              in_valid;
    logic              in_ready;
    logic signed [11:0] out_i;
    logic signed [11:0] out_q;
    logic              out_valid;
    logic              out_ready;

    frequency_modulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int acc_m    = 0;

    int exp_i_q[$];
    int exp_q_q[$];
    int seen_i[$];
    int seen_q[$];

    bit hold_pending = 1'b0;
    int hold_i;
    int hold_q;

    int tbl4_i[4] = '{2047, 0, -2047, 0};
    int tbl4_q[4] = '{0, 2047, 0, -2047};
    int tbl8_i[8] = '{2047, 1447, 0, -1447, -2047, -1447, 0, 1447};
    int tbl8_q[8] = '{0, -1447, -2047, -1447, 0, 1447, 2047, 1447};

    function automatic int rnd(real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // Reference: full-circle trig on the phase truncated to the table grid.
    function automatic void model(input int p, output int ei, output int eq);
        real th;
        th = 2.0 * 3.14159265358979323846 * real'(p & 32'hFF00) / 65536.0;
        ei = rnd(2047.0 * $cos(th));
        eq = rnd(2047.0 * $sin(th));
    endfunction

    always @(negedge clk) begin
        int ei, eq, w;
        if (hold_pending && rst_n === 1'b1) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_i !== 12'(hold_i) || out_q !== 12'(hold_q)) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                         out_valid, out_i, out_q, hold_i, hold_q);
            end
        end
        hold_pending = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst_n === 1'b1);
        hold_i = int'(out_i);
        hold_q = int'(out_q);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            seen_i.push_back(int'(out_i));
            seen_q.push_back(int'(out_q));
            if (exp_i_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got (%0d,%0d) want no output", out_i, out_q);
            end else begin
                ei = exp_i_q.pop_front();
                eq = exp_q_q.pop_front();
                if (int'(out_i) !== ei || int'(out_q) !== eq) begin
                    n_fail++;
                    $display("FAIL sb_data: got (%0d,%0d) want (%0d,%0d)",
                             out_i, out_q, ei, eq);
                end
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            model(acc_m, ei, eq);
            exp_i_q.push_back(ei);
            exp_q_q.push_back(eq);
            w = int'(in);
            acc_m = (acc_m + w * 16) & 32'hFFFF;
            n_acc++;
        end
        if (rst_n === 1'b0) begin
            exp_i_q.delete();
            exp_q_q.delete();
            acc_m = 0;
        end
    end

    task automatic stream(input int word, input int n, input bit stall);
        int target = n_acc + n;
        int cyc = 0;
        in = 12'(word);
        while (1) begin
            @(posedge clk);
            #1;
            if (n_acc >= target) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                break;
            end
            if (cyc++ > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_timeout: got %0d accepts want %0d", n_acc, target);
                in_valid = 1'b0;
                break;
            end
            in_valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (exp_i_q.size() == 0) break;
        end
        n_checks++;
        if (exp_i_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_i_q.size());
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n     = 1'b0;
        in        = 12'hAAA;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        repeat (1000) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || out_i !== 12'sd0 || out_q !== 12'sd0 || in_ready !== 1'b0) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL reset_state: got v=%b i=%0d q=%0d rdy=%b want all 0",
                             out_valid, out_i, out_q, in_ready);
            end
        end
    endtask

    task automatic test_zero();
        @(posedge clk);
        #1;
        n_acc = 0;
        in = 12'sd0;
        in_valid = 1'b1;
        rst_n = 1'b1;
        seen_i.delete();
        seen_q.delete();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL latency_edge%0d: got out_valid=%b want %b", k, out_valid, k == 3);
            end
        end
        stream(0, 500 - n_acc, 1'b0);
        drain();
        n_checks++;
        if (seen_i.size() != 500) begin
            n_fail++;
            $display("FAIL zero_count: got %0d want 500", seen_i.size());
        end
        foreach (seen_i[k]) begin
            n_checks++;
            if (seen_i[k] != 2047 || seen_q[k] != 0) begin
                n_fail++;
                $display("FAIL zero_iq[%0d]: got (%0d,%0d) want (2047,0)", k, seen_i[k], seen_q[k]);
            end
        end
    endtask

    task automatic test_quarter();
        seen_i.delete();
        seen_q.delete();
        stream(1024, 40, 1'b0);
        drain();
        n_checks++;
        if (seen_i.size() != 40) begin
            n_fail++;
            $display("FAIL quarter_count: got %0d want 40", seen_i.size());
        end
        foreach (seen_i[k]) begin
            n_checks++;
            if (seen_i[k] != tbl4_i[k % 4] || seen_q[k] != tbl4_q[k % 4]) begin
                n_fail++;
                $display("FAIL quarter_iq[%0d]: got (%0d,%0d) want (%0d,%0d)",
                         k, seen_i[k], seen_q[k], tbl4_i[k % 4], tbl4_q[k % 4]);
            end
        end
    endtask

    task automatic test_negative();
        seen_i.delete();
        seen_q.delete();
        stream(-512, 16, 1'b0);
        drain();
        n_checks++;
        if (seen_i.size() != 16) begin
            n_fail++;
            $display("FAIL neg_count: got %0d want 16", seen_i.size());
        end
        foreach (seen_i[k]) begin
            n_checks++;
            if (seen_i[k] != tbl8_i[k % 8] || seen_q[k] != tbl8_q[k % 8]) begin
                n_fail++;
                $display("FAIL neg_iq[%0d]: got (%0d,%0d) want (%0d,%0d)",
                         k, seen_i[k], seen_q[k], tbl8_i[k % 8], tbl8_q[k % 8]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        seen_i.delete();
        seen_q.delete();
        stream(1024, 200, 1'b1);
        drain();
        n_checks++;
        if (seen_i.size() != 200) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want 200", seen_i.size());
        end
        foreach (seen_i[k]) begin
            n_checks++;
            if (seen_i[k] != tbl4_i[k % 4] || seen_q[k] != tbl4_q[k % 4]) begin
                n_fail++;
                $display("FAIL stall_iq[%0d]: got (%0d,%0d) want (%0d,%0d)",
                         k, seen_i[k], seen_q[k], tbl4_i[k % 4], tbl4_q[k % 4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        stream(1024, 5, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_i.delete();
        seen_q.delete();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_valid: got %b want 0", out_valid);
        end
        stream(1024, 8, 1'b0);
        drain();
        n_checks++;
        if (seen_i.size() < 1 || seen_i[0] != 2047 || seen_q[0] != 0) begin
            n_fail++;
            $display("FAIL mid_rst_first: got n=%0d (%0d,%0d) want (2047,0)",
                     seen_i.size(), seen_i.size() ? seen_i[0] : 0,
                     seen_q.size() ? seen_q[0] : 0);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_quarter();
        test_negative();
        test_back_to_back_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
